cosim_loopback_buffer: RTL and testbench

COSIM_LOOPBACK_BUFFER -- requirements
Module: cosim_loopback_buffer

---
 rtl/cosim_loopback_buffer.sv | 93 +++++++++
 tb/tb_cosim_loopback_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cosim_loopback_buffer.sv
// Loopback echo buffer: messages received from a co-simulation endpoint are queued
// in a small FIFO and sent back, optionally bit-inverted, with one cycle of latency.
module cosim_loopback_buffer #(
  parameter int unsigned WIDTH = 32'd192,
  parameter int unsigned DEPTH = 32'd4,
  parameter int unsigned MODE  = 32'd0,
  parameter int unsigned CNT_W = 32'd32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       DataOutValid,
  output logic                       DataOutReady,
  input  logic [WIDTH-1:0]           DataOut,
  output logic                       DataInValid,
  input  logic                       DataInReady,
  output logic [WIDTH-1:0]           DataIn,
  output logic [CNT_W-1:0]           RecvCount,
  output logic [CNT_W-1:0]           SentCount,
  output logic [$clog2(DEPTH+1)-1:0] Occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 32'd1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [OCC_W-1:0] occ_r;
  logic [CNT_W-1:0] recvCnt_r;
  logic [CNT_W-1:0] sentCnt_r;

  logic             push_s;
  logic             pop_s;
  logic [OCC_W-1:0] occNext_s;

  function automatic logic [WIDTH-1:0] echoXform(input logic [WIDTH-1:0] v);
    if (MODE == 32'd1) begin
      echoXform = ~v;
    end else begin
      echoXform = v;
    end
  endfunction

  // Ready and valid depend only on registered occupancy, never on the far side's handshake.
  assign DataOutReady = (occ_r != OCC_W'(DEPTH));
  assign DataInValid  = (occ_r != {OCC_W{1'b0}});
  assign DataIn       = echoXform(mem_r[rdPtr_r]);
  assign RecvCount    = recvCnt_r;
  assign SentCount    = sentCnt_r;
  assign Occupancy    = occ_r;

  assign push_s = DataOutValid && DataOutReady;
  assign pop_s  = DataInValid && DataInReady;

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    occNext_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occNext_s = occ_r + OCC_W'(1);
      2'b01:   occNext_s = occ_r - OCC_W'(1);
      default: occNext_s = occ_r;
    endcase
  end

  // Control state: pointers, occupancy and message counters; reset drops any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_r   <= {PTR_W{1'b0}};
      rdPtr_r   <= {PTR_W{1'b0}};
      occ_r     <= {OCC_W{1'b0}};
      recvCnt_r <= {CNT_W{1'b0}};
      sentCnt_r <= {CNT_W{1'b0}};
    end else begin
      occ_r <= occNext_s;
      if (push_s) begin
        wrPtr_r   <= wrPtr_r + PTR_W'(1);
        recvCnt_r <= recvCnt_r + CNT_W'(1);
      end
      if (pop_s) begin
        rdPtr_r   <= rdPtr_r + PTR_W'(1);
        sentCnt_r <= sentCnt_r + CNT_W'(1);
      end
    end
  end

  // Payload storage, written only on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wrPtr_r] <= DataOut;
    end
  end

endmodule

// File: tb/tb_cosim_loopback_buffer.sv
// Self-checking bench: two buffer instances (pass-through, 32-bit counters / invert,
// 4-bit counters) share stimulus and are compared against a queue-based model.
module tb_cosim_loopback_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 192;

  logic           clk = 1'b0;
  logic           rst;
  logic           DataOutValid;
  logic [W-1:0]   DataOut;
  logic           DataInReady;

  logic           DataOutReadyA, DataInValidA;
  logic [W-1:0]   DataInA;
  logic [31:0]    RecvCountA, SentCountA;
  logic [2:0]     OccupancyA;

  logic           DataOutReadyB, DataInValidB;
  logic [W-1:0]   DataInB;
  logic [3:0]     RecvCountB, SentCountB;
  logic [2:0]     OccupancyB;

  int nCmp = 0;
  int nBad = 0;

  logic [W-1:0] q[$];
  int unsigned  recvM = 0;
  int unsigned  sentM = 0;

  always #5 clk = ~clk;

  cosim_loopback_buffer #(.WIDTH(W), .DEPTH(DEPTH), .MODE(0), .CNT_W(32)) dutA (
    .clk(clk), .rst(rst),
    .DataOutValid(DataOutValid), .DataOutReady(DataOutReadyA), .DataOut(DataOut),
    .DataInValid(DataInValidA), .DataInReady(DataInReady), .DataIn(DataInA),
    .RecvCount(RecvCountA), .SentCount(SentCountA), .Occupancy(OccupancyA)
  );

  cosim_loopback_buffer #(.WIDTH(W), .DEPTH(DEPTH), .MODE(1), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst),
    .DataOutValid(DataOutValid), .DataOutReady(DataOutReadyB), .DataOut(DataOut),
    .DataInValid(DataInValidB), .DataInReady(DataInReady), .DataIn(DataInB),
    .RecvCount(RecvCountB), .SentCount(SentCountB), .Occupancy(OccupancyB)
  );

  typedef struct {
    logic        r;
    logic        ov;
    logic        ir;
    logic [31:0] d;
    logic        eRdy;
    logic        eVld;
    int          eOcc;
    logic [31:0] eData;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare both instances against the model's current view.
  task automatic checkAll();
    logic [3:0] recv4, sent4;
    recv4 = recvM[3:0];
    sent4 = sentM[3:0];
    chk("readyA", W'(DataOutReadyA), W'(q.size() != DEPTH));
    chk("validA", W'(DataInValidA), W'(q.size() != 0));
    chk("occA", W'(OccupancyA), W'(q.size()));
    chk("recvA", W'(RecvCountA), W'(recvM));
    chk("sentA", W'(SentCountA), W'(sentM));
    chk("readyB", W'(DataOutReadyB), W'(q.size() != DEPTH));
    chk("validB", W'(DataInValidB), W'(q.size() != 0));
    chk("occB", W'(OccupancyB), W'(q.size()));
    chk("recvB", W'(RecvCountB), W'(recv4));
    chk("sentB", W'(SentCountB), W'(sent4));
    chk("invarB", W'(4'(RecvCountB - SentCountB)), W'(OccupancyB));
    if (q.size() != 0) begin
      chk("dataA", DataInA, q[0]);
      chk("dataB", DataInB, ~q[0]);
    end
  endtask

  // Drive one cycle of stimulus (called at a falling edge), advance the model, check.
  task automatic cycle(input logic r, input logic ov, input logic [W-1:0] d, input logic ir);
    bit doPush, doPop;
    rst = r; DataOutValid = ov; DataOut = d; DataInReady = ir;
    @(posedge clk);
    if (r) begin
      q.delete();
      recvM = 0;
      sentM = 0;
    end else begin
      doPop  = ir && (q.size() != 0);
      doPush = ov && (q.size() != DEPTH);
      if (doPop) void'(q.pop_front());
      if (doPush) q.push_back(d);
      recvM += 32'(doPush);
      sentM += 32'(doPop);
    end
    @(negedge clk);
    checkAll();
  endtask

  function automatic logic [W-1:0] rndData();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0] ones;
    ones = '1;
    rst = 1'b1; DataOutValid = 1'b0; DataOut = '0; DataInReady = 1'b0;

    //            r     ov    ir    d            rdy   vld   occ  data
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h000A0B0C, 1'b1, 1'b1, 1, 32'h000A0B0C};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,       1'b1, 1'b0, 0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'd1,       1'b1, 1'b1, 1, 32'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'd2,       1'b1, 1'b1, 2, 32'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'd3,       1'b1, 1'b1, 3, 32'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'd4,       1'b0, 1'b1, 4, 32'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'd5,       1'b0, 1'b1, 4, 32'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'd5,       1'b1, 1'b1, 3, 32'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'd5,       1'b1, 1'b1, 3, 32'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'd0,       1'b1, 1'b1, 2, 32'd4};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'd0,       1'b1, 1'b1, 1, 32'd5};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'd0,       1'b1, 1'b0, 0, 32'd0};

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].r, tbl[i].ov, W'(tbl[i].d), tbl[i].ir);
      chk($sformatf("tbl%0d_rdy", i), W'(DataOutReadyA), W'(tbl[i].eRdy));
      chk($sformatf("tbl%0d_vld", i), W'(DataInValidA), W'(tbl[i].eVld));
      chk($sformatf("tbl%0d_occ", i), W'(OccupancyA), W'(tbl[i].eOcc));
      if (tbl[i].eVld) chk($sformatf("tbl%0d_data", i), DataInA, W'(tbl[i].eData));
      if (i == 2) begin
        chk("echo_recv", W'(RecvCountA), W'(32'd1));
        chk("echo_sent", W'(SentCountA), W'(32'd1));
      end
    end

    // Steady push+pop at occupancy 2; pointers wrap more than twice.
    cycle(1'b0, 1'b1, W'(32'h100), 1'b0);
    cycle(1'b0, 1'b1, W'(32'h101), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, W'(32'h102 + i), 1'b1);
      chk("steady_occ", W'(OccupancyA), W'(3'd2));
      chk("steady_data", DataInA, W'(32'h101 + i));
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Inversion mode on the B instance.
    cycle(1'b0, 1'b1, '0, 1'b0);
    chk("inv_zero", DataInB, ones);
    cycle(1'b0, 1'b1, ones, 1'b1);
    chk("inv_ones", DataInB, '0);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Reset with handshakes active while three messages are buffered.
    cycle(1'b0, 1'b1, W'(32'hA1), 1'b0);
    cycle(1'b0, 1'b1, W'(32'hA2), 1'b0);
    cycle(1'b0, 1'b1, W'(32'hA3), 1'b0);
    chk("pre_rst_occ", W'(OccupancyA), W'(3'd3));
    cycle(1'b1, 1'b1, W'(32'hA4), 1'b1);
    chk("rst_occ", W'(OccupancyA), W'(3'd0));
    chk("rst_recv", W'(RecvCountA), W'(32'd0));
    chk("rst_sent", W'(SentCountA), W'(32'd0));
    chk("rst_vld", W'(DataInValidA), W'(1'b0));
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("post_rst_vld", W'(DataInValidA), W'(1'b0));
    end

    // 17 push/pop pairs wrap the 4-bit counters back to 1.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 1'b1, rndData(), 1'b0);
      cycle(1'b0, 1'b0, rndData(), 1'b1);
    end
    chk("wrap_recvB", W'(RecvCountB), W'(4'd1));
    chk("wrap_sentB", W'(SentCountB), W'(4'd1));
    chk("wrap_recvA", W'(RecvCountA), W'(32'd17));

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(63) == 0), $urandom_range(1), rndData(), $urandom_range(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
